// File: rtl/tpu_tile_sched_if.sv
// Interface bundling the host start/config signals, the A/B/O buffer ports
// and the TPU in/out handshakes for the tile scheduler.
interface tpu_tile_sched_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 6,
    parameter int TILE_W = 4
);
    // Host start/config
    logic              start;
    logic [TILE_W-1:0] mt;
    logic [TILE_W-1:0] nt;
    logic [CNT_W-1:0]  k_len;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_o;
    // Global buffer ports
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx_a;
    logic [ADDR_W-1:0] rd_idx_b;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_idx_o;
    // TPU handshakes
    logic              tpu_clear;
    logic              tpu_in_valid;
    logic              tpu_in_ready;
    logic              tpu_out_valid;
    logic              tpu_out_ready;
    // Status
    logic              busy;
    logic              done;
    logic              err;

    // Host / TPU / buffer side
    modport master (
        output start, mt, nt, k_len, base_a, base_b, base_o,
        output tpu_in_ready, tpu_out_valid,
        input  rd_en, rd_idx_a, rd_idx_b, wr_en_o, wr_idx_o,
        input  tpu_clear, tpu_in_valid, tpu_out_ready,
        input  busy, done, err
    );

    // Scheduler side
    modport slave (
        input  start, mt, nt, k_len, base_a, base_b, base_o,
        input  tpu_in_ready, tpu_out_valid,
        output rd_en, rd_idx_a, rd_idx_b, wr_en_o, wr_idx_o,
        output tpu_clear, tpu_in_valid, tpu_out_ready,
        output busy, done, err
    );
endinterface

// File: rtl/tpu_tile_sched.sv
// Tile-level scheduler: walks an mt x nt grid of output tiles in row-major
// order, streams k_len A/B row pairs into the TPU per tile, then collects
// OUT_ROWS result rows into the output buffer.
module tpu_tile_sched #(
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 6,
    parameter int TILE_W   = 4,
    parameter int OUT_ROWS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tpu_tile_sched_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_FEED    = 3'd2,
        S_COLLECT = 3'd3,
        S_NEXT    = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(OUT_ROWS - 32'd1);

    state_t            r_state;
    state_t            w_next;
    logic [TILE_W-1:0] r_mt, r_nt, r_ti, r_tj;
    logic [CNT_W-1:0]  r_klen, r_r, r_q;
    logic [ADDR_W-1:0] r_base_a, r_base_b, r_base_o;
    logic              r_in_valid, r_done, r_err;

    logic              w_cfg_ok;
    logic              w_last_beat, w_last_row, w_last_tile, w_tj_last;
    logic              w_rd_en, w_clear, w_out_ready, w_wr_en, w_busy;
    logic [ADDR_W-1:0] w_calc_a, w_calc_b, w_calc_o;
    logic [ADDR_W-1:0] w_rd_idx_a, w_rd_idx_b, w_wr_idx_o;

    // A zero dimension makes the job empty, so such a start is rejected.
    assign w_cfg_ok    = (bus.mt != '0) && (bus.nt != '0) && (bus.k_len != '0);
    assign w_last_beat = (r_r == (r_klen - CNT_W'(1'b1)));
    assign w_last_row  = (r_q == Q_LAST);
    assign w_tj_last   = (r_tj == (r_nt - TILE_W'(1'b1)));
    assign w_last_tile = w_tj_last && (r_ti == (r_mt - TILE_W'(1'b1)));

    // Address arithmetic is done at ADDR_W so every sum wraps mod 2^ADDR_W.
    assign w_calc_a = r_base_a + ADDR_W'(r_ti) * ADDR_W'(r_klen) + ADDR_W'(r_r);
    assign w_calc_b = r_base_b + ADDR_W'(r_tj) * ADDR_W'(r_klen) + ADDR_W'(r_r);
    assign w_calc_o = r_base_o
                    + (ADDR_W'(r_ti) * ADDR_W'(r_nt) + ADDR_W'(r_tj)) * ADDR_W'(OUT_ROWS)
                    + ADDR_W'(r_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and combinational strobes; indices are forced to zero outside their phase.
    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_clear     = 1'b0;
        w_out_ready = 1'b0;
        w_wr_en     = 1'b0;
        w_busy      = 1'b1;
        w_rd_idx_a  = '0;
        w_rd_idx_b  = '0;
        w_wr_idx_o  = '0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start && w_cfg_ok) begin
                    w_next = S_LAUNCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LAUNCH: begin
                w_clear = 1'b1;
                w_next  = S_FEED;
            end
            S_FEED: begin
                w_rd_en    = bus.tpu_in_ready;
                w_rd_idx_a = w_calc_a;
                w_rd_idx_b = w_calc_b;
                if (bus.tpu_in_ready && w_last_beat) begin
                    w_next = S_COLLECT;
                end else begin
                    w_next = S_FEED;
                end
            end
            S_COLLECT: begin
                w_out_ready = 1'b1;
                w_wr_en     = bus.tpu_out_valid;
                w_wr_idx_o  = w_calc_o;
                if (bus.tpu_out_valid && w_last_row) begin
                    w_next = S_NEXT;
                end else begin
                    w_next = S_COLLECT;
                end
            end
            S_NEXT: begin
                if (w_last_tile) begin
                    w_next = S_FIN;
                end else begin
                    w_next = S_LAUNCH;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Config capture and tile / beat / row counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mt     <= '0;
            r_nt     <= '0;
            r_klen   <= '0;
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_o <= '0;
            r_ti     <= '0;
            r_tj     <= '0;
            r_r      <= '0;
            r_q      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_cfg_ok) begin
                        r_mt     <= bus.mt;
                        r_nt     <= bus.nt;
                        r_klen   <= bus.k_len;
                        r_base_a <= bus.base_a;
                        r_base_b <= bus.base_b;
                        r_base_o <= bus.base_o;
                        r_ti     <= '0;
                        r_tj     <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_r <= '0;
                    r_q <= '0;
                end
                S_FEED: begin
                    if (w_rd_en) begin
                        r_r <= r_r + CNT_W'(1'b1);
                    end
                end
                S_COLLECT: begin
                    if (w_wr_en) begin
                        r_q <= r_q + CNT_W'(1'b1);
                    end
                end
                S_NEXT: begin
                    if (w_tj_last) begin
                        r_tj <= '0;
                        r_ti <= r_ti + TILE_W'(1'b1);
                    end else begin
                        r_tj <= r_tj + TILE_W'(1'b1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs: input-valid tracks the read one cycle later; done/err are pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_valid <= w_rd_en;
            r_done     <= (w_next == S_FIN);
            r_err      <= (r_state == S_IDLE) && bus.start && !w_cfg_ok;
        end
    end

    assign bus.rd_en         = w_rd_en;
    assign bus.rd_idx_a      = w_rd_idx_a;
    assign bus.rd_idx_b      = w_rd_idx_b;
    assign bus.tpu_clear     = w_clear;
    assign bus.tpu_in_valid  = r_in_valid;
    assign bus.tpu_out_ready = w_out_ready;
    assign bus.wr_en_o       = w_wr_en;
    assign bus.wr_idx_o      = w_wr_idx_o;
    assign bus.busy          = w_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
endmodule

// File: tb/tb_tpu_tile_sched.sv
// Directed bench for tpu_tile_sched: drives jobs through the interface,
// models a TPU that returns OUT_ROWS rows after a gap, and checks read/write
// index streams and status pulses against hand-computed values.
module tb_tpu_tile_sched;
    localparam int ADDR_W = 10, CNT_W = 6, TILE_W = 4, OUT_ROWS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpu_tile_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TILE_W(TILE_W)) bus();

    tpu_tile_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TILE_W(TILE_W), .OUT_ROWS(OUT_ROWS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int rd_a_q[$], rd_b_q[$], rd_cyc_q[$], wr_q[$];
    int n_clear, n_done, n_err, n_busy, lag_err, done_cyc, fall_cyc;
    logic prev_rd, prev_busy;

    // TPU result model: after tpu_out_ready is first seen, wait resp_gap cycles then send OUT_ROWS rows.
    int resp_gap = 3;
    int phase = 0, gap = 0, sent = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus.tpu_out_valid = 1'b0;
            phase = 0;
        end else if (phase == 0) begin
            if (bus.tpu_out_ready) begin
                gap = resp_gap;
                phase = 1;
            end
        end else if (phase == 1) begin
            if (gap == 0) begin
                bus.tpu_out_valid = 1'b1;
                sent = 0;
                phase = 2;
            end else begin
                gap--;
            end
        end else begin
            sent++;
            if (sent == OUT_ROWS) begin
                bus.tpu_out_valid = 1'b0;
                phase = 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (bus.rd_en) begin
            rd_a_q.push_back(int'(bus.rd_idx_a));
            rd_b_q.push_back(int'(bus.rd_idx_b));
            rd_cyc_q.push_back(cyc);
        end
        if (bus.wr_en_o) wr_q.push_back(int'(bus.wr_idx_o));
        if (bus.tpu_clear) n_clear++;
        if (bus.done) begin n_done++; done_cyc = cyc; end
        if (bus.err) n_err++;
        if (bus.busy) n_busy++;
        if (!bus.busy && prev_busy) fall_cyc = cyc;
        if (bus.tpu_in_valid !== prev_rd) lag_err++;
        prev_rd = bus.rd_en;
        prev_busy = bus.busy;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_mon();
        rd_a_q.delete(); rd_b_q.delete(); rd_cyc_q.delete(); wr_q.delete();
        n_clear = 0; n_done = 0; n_err = 0; n_busy = 0; lag_err = 0;
        done_cyc = -1; fall_cyc = -1; prev_rd = 1'b0; prev_busy = 1'b0;
    endtask

    task automatic launch(input int m, input int n, input int k, input int ba, input int bb, input int bo);
        bus.mt = TILE_W'(m); bus.nt = TILE_W'(n); bus.k_len = CNT_W'(k);
        bus.base_a = ADDR_W'(ba); bus.base_b = ADDR_W'(bb); bus.base_o = ADDR_W'(bo);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cyc >= 0) begin seen = 1; break; end
        end
        repeat (2) tick();
        check_eq({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_strobes"}, {24'd0, bus.rd_en, bus.tpu_in_valid, bus.tpu_clear, bus.tpu_out_ready,
                                      bus.wr_en_o, bus.busy, bus.done, bus.err}, 32'd0);
        check_eq({tag, "_idx"}, {2'd0, bus.rd_idx_a, bus.rd_idx_b, bus.wr_idx_o}, 32'd0);
    endtask

    int exp_a0[6] = '{100, 100, 100, 105, 105, 105};
    int exp_b0[6] = '{200, 205, 210, 200, 205, 210};
    int exp_wrap[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
    int pat[6] = '{1, 0, 0, 1, 0, 1};

    initial begin
        int bad;
        bus.start = 1'b0; bus.mt = '0; bus.nt = '0; bus.k_len = '0;
        bus.base_a = '0; bus.base_b = '0; bus.base_o = '0; bus.tpu_in_ready = 1'b1;
        clr_mon();
        repeat (3) tick();
        check_outputs_zero("rst_hold");
        rst_n = 1'b1;
        tick();
        check_outputs_zero("rst_idle");

        // 1x1 tile, k_len=4
        clr_mon();
        launch(1, 1, 4, 0, 0, 0);
        wait_done(100, "t1");
        check_eq("t1_rd_cnt", rd_a_q.size(), 4);
        if (rd_a_q.size() == 4) begin
            bad = 0;
            for (int i = 0; i < 4; i++) if (rd_a_q[i] != i || rd_b_q[i] != i) bad++;
            check_eq("t1_rd_idx_bad", bad, 0);
            check_eq("t1_rd_span", rd_cyc_q[3] - rd_cyc_q[0], 3);
        end
        check_eq("t1_wr_cnt", wr_q.size(), 8);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] != i) bad++;
        check_eq("t1_wr_idx_bad", bad, 0);
        check_eq("t1_done_cnt", n_done, 1);
        check_eq("t1_busy_fall_after_done", fall_cyc - done_cyc, 1);
        check_eq("t1_lag_err", lag_err, 0);
        check_eq("t1_clear_cnt", n_clear, 1);

        // 2x3 tiles, k_len=5, nonzero bases
        clr_mon();
        launch(2, 3, 5, 100, 200, 300);
        wait_done(400, "t2");
        check_eq("t2_clear_cnt", n_clear, 6);
        check_eq("t2_rd_cnt", rd_a_q.size(), 30);
        check_eq("t2_wr_cnt", wr_q.size(), 48);
        if (rd_a_q.size() == 30) begin
            bad = 0;
            for (int t = 0; t < 6; t++) if (rd_a_q[t*5] != exp_a0[t] || rd_b_q[t*5] != exp_b0[t]) bad++;
            check_eq("t2_tile_order_bad", bad, 0);
            bad = 0;
            for (int i = 0; i < 5; i++) if (rd_a_q[25+i] != 105 + i || rd_b_q[25+i] != 210 + i) bad++;
            check_eq("t2_tile12_rd_bad", bad, 0);
        end
        if (wr_q.size() == 48) begin
            bad = 0;
            for (int i = 0; i < 48; i++) if (wr_q[i] != 300 + i) bad++;
            check_eq("t2_wr_seq_bad", bad, 0);
            check_eq("t2_tile12_wr_first", wr_q[40], 340);
            check_eq("t2_tile12_wr_last", wr_q[47], 347);
        end
        check_eq("t2_lag_err", lag_err, 0);

        // tpu_in_ready stalls during FEED
        clr_mon();
        launch(1, 1, 3, 0, 0, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.tpu_in_ready = pat[i][0];
            tick();
        end
        bus.tpu_in_ready = 1'b1;
        wait_done(100, "t3");
        check_eq("t3_rd_cnt", rd_a_q.size(), 3);
        if (rd_a_q.size() == 3) begin
            bad = 0;
            for (int i = 0; i < 3; i++) if (rd_a_q[i] != i || rd_b_q[i] != i) bad++;
            check_eq("t3_rd_idx_bad", bad, 0);
            check_eq("t3_beat1_gap", rd_cyc_q[1] - rd_cyc_q[0], 3);
            check_eq("t3_beat2_gap", rd_cyc_q[2] - rd_cyc_q[0], 5);
        end
        check_eq("t3_lag_err", lag_err, 0);
        check_eq("t3_wr_cnt", wr_q.size(), 8);

        // Rejected starts: k_len=0, then nt=0
        clr_mon();
        launch(2, 2, 0, 0, 0, 0);
        repeat (4) tick();
        check_eq("t4k_err_cnt", n_err, 1);
        check_eq("t4k_busy_cnt", n_busy, 0);
        check_eq("t4k_rd_wr_cnt", rd_a_q.size() + wr_q.size(), 0);
        clr_mon();
        launch(2, 0, 3, 0, 0, 0);
        repeat (4) tick();
        check_eq("t4n_err_cnt", n_err, 1);
        check_eq("t4n_busy_cnt", n_busy, 0);
        check_eq("t4n_rd_wr_cnt", rd_a_q.size() + wr_q.size(), 0);

        // Output index wrap
        clr_mon();
        launch(1, 1, 2, 0, 0, 1020);
        wait_done(100, "t5");
        check_eq("t5_wr_cnt", wr_q.size(), 8);
        if (wr_q.size() == 8) begin
            bad = 0;
            for (int i = 0; i < 8; i++) if (wr_q[i] != exp_wrap[i]) bad++;
            check_eq("t5_wrap_bad", bad, 0);
        end

        // Async reset during FEED of the second tile, then a clean 1x1 job
        clr_mon();
        launch(2, 2, 4, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_clear == 2) break;
        end
        tick();
        check_eq("t6_pre_rd_en", bus.rd_en, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clr_mon();
        launch(1, 1, 2, 0, 0, 0);
        wait_done(100, "t6");
        check_eq("t6_clear_cnt", n_clear, 1);
        check_eq("t6_rd_cnt", rd_a_q.size(), 2);
        if (rd_a_q.size() == 2) check_eq("t6_rd_idx", {rd_a_q[0][15:0], rd_a_q[1][15:0]}, {16'd0, 16'd1});
        check_eq("t6_wr_cnt", wr_q.size(), 8);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] != i) bad++;
        check_eq("t6_wr_idx_bad", bad, 0);
        check_eq("t6_done_cnt", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/tpu_tile_sched.md
Name: tpu_tile_sched

Overview:
Tile-level scheduler for the TPU datapath. It walks an mt x nt grid of output tiles. For each tile it streams k_len row pairs from global buffers A and B into the TPU, then collects OUT_ROWS result rows and writes them into the output global buffer. It sits between the host start/config interface and the buffer read/write ports plus the TPU in/out handshakes, and replaces the fixed single-pass sequencing with multi-tile operation.

Parameters:
ADDR_W, 10, global buffer index width
CNT_W, 6, width of k_len and row counters (k_len max 2^CNT_W-1)
TILE_W, 4, width of mt/nt and tile counters
OUT_ROWS, 8, result rows the TPU returns per tile

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch request, sampled in IDLE only
mt  in  TILE_W  number of A row-tiles, captured at start
nt  in  TILE_W  number of B column-tiles, captured at start
k_len  in  CNT_W  rows streamed per tile, captured at start
base_a  in  ADDR_W  A buffer base index, captured at start
base_b  in  ADDR_W  B buffer base index, captured at start
base_o  in  ADDR_W  output buffer base index, captured at start
rd_en  out  1  read strobe to A and B buffers (1-cycle read latency)
rd_idx_a  out  ADDR_W  A read index
rd_idx_b  out  ADDR_W  B read index
tpu_clear  out  1  one-cycle accumulator clear before each tile
tpu_in_valid  out  1  buffer data on the TPU input is valid
tpu_in_ready  in  1  TPU accepts a beat presented next cycle
tpu_out_valid  in  1  TPU result row valid
tpu_out_ready  out  1  scheduler accepts a result row
wr_en_o  out  1  output buffer write strobe
wr_idx_o  out  ADDR_W  output buffer write index
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the job completes
err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: state=IDLE. All counters, captured config, tpu_in_valid, done and err are 0. All combinational outputs evaluate to 0 in IDLE.
- States: IDLE, LAUNCH, FEED, COLLECT, NEXT, FIN.
- IDLE: on start=1 with mt, nt and k_len all nonzero, capture the config, set ti=tj=0, and go to LAUNCH. On start=1 with any of them zero, pulse err next cycle and stay in IDLE. start is ignored while busy.
- LAUNCH (1 cycle): tpu_clear=1, r=0, then go to FEED.
- FEED: rd_en = tpu_in_ready. rd_idx_a = base_a + ti*k_len + r. rd_idx_b = base_b + tj*k_len + r. Address sums wrap mod 2^ADDR_W.
  - On each cycle with rd_en=1, r increments. tpu_in_valid is the registered value of rd_en (data arrives 1 cycle later).
  - When rd_en=1 and r==k_len-1, go to COLLECT. tpu_in_valid for that last beat is still asserted on the first COLLECT cycle.
  - tpu_in_ready=0 holds r and issues no read.
- COLLECT: tpu_out_ready=1 and wr_en_o = tpu_out_valid. wr_idx_o = base_o + (ti*nt + tj)*OUT_ROWS + q, where q is the result-row counter (reset in LAUNCH).
  - q increments on each write. On the write with q==OUT_ROWS-1, go to NEXT.
  - tpu_out_valid is ignored in every other state (tpu_out_ready=0).
- NEXT (1 cycle): if tj<nt-1 then tj++. Else tj=0 and ti++.
  - If ti==mt-1 and tj==nt-1 were the last tile, go to FIN. Otherwise go to LAUNCH.
- FIN (1 cycle): done=1 registered (high during the cycle after FIN entry is computed, exactly one cycle), busy=1, then go to IDLE.
- Tile order is row-major: ti outer, tj inner. Total tiles = mt*nt. Total writes = mt*nt*OUT_ROWS.
- Minimum tile cost with ready always high: 1 (LAUNCH) + k_len (FEED) + COLLECT wait + 1 (NEXT).
- Asynchronous reset mid-job returns to IDLE immediately with all outputs 0. No partial state is retained.
- A start asserted in the same cycle as FIN is ignored. It is accepted on the first IDLE cycle only if still held.

Test Plan:
- mt=1, nt=1, k_len=4, bases=0, ready always 1, TPU returns 8 rows 3 cycles after last beat -> rd_idx 0,1,2,3 on consecutive cycles. tpu_in_valid lags by 1. wr_idx_o 0..7. done single pulse. busy falls the cycle after done.
- mt=2, nt=3, k_len=5, base_a=100, base_b=200, base_o=300 -> tile order (0,0),(0,1),(0,2),(1,0)...; tile (1,2) reads A 105..109 and B 210..214 and writes 340..347. 48 total writes. One tpu_clear per tile (6 total).
- tpu_in_ready toggled 1,0,0,1,0,1 during FEED with k_len=3 -> exactly 3 rd_en beats. r holds while ready=0. Indices never skip or repeat.
- start with k_len=0 (and separately with nt=0) -> err pulses 1 cycle, busy stays 0, no rd_en, no wr_en_o.
- base_o=1020, ADDR_W=10, mt=1, nt=1 -> wr_idx_o 1020,1021,1022,1023,0,1,2,3 (wrap).
- Drop rst_n during FEED of tile 2 of a 2x2 job -> all outputs 0 immediately. A new start with mt=nt=1 runs a clean single tile from LAUNCH.
